// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 16-bit core register file.
// Holds the default widths, the register-address and data-word types, and
// the index of the hardwired zero register.
package regfile_2r1w_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_word_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One registered read port of the register file.
// Registers the addressed word and busy bit one cycle after a request.
// The same-edge write and reservation are forwarded, so the port returns
// the post-edge state. The zero register is masked to data 0 / busy 0.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   en, addr               read request and address
//   mem_word, busy_bit     stored word / busy bit at addr (pre-edge)
//   wr_en/wr_addr/wr_data  effective write this edge
//   rsv_en/rsv_addr        effective reservation this edge
//   data, valid, busy      registered read result
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              busy_bit,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy
);

  logic is_zero;
  logic wr_hit;
  logic rsv_hit;

  assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
  assign wr_hit  = wr_en && (wr_addr == addr);
  assign rsv_hit = rsv_en && (rsv_addr == addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= en;
      // data/busy hold when no request is made
      if (en) begin
        if (is_zero) begin
          data <= '0;
          busy <= 1'b0;
        end else begin
          data <= wr_hit ? wr_data : mem_word;
          // a reservation on the same edge outranks the write's clear
          busy <= rsv_hit | (busy_bit & ~wr_hit);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with write-first bypass, optional
// hardwired zero register and a per-register busy scoreboard.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ra_en/ra_addr -> ra_data/ra_valid/ra_busy   read port A (1-cycle)
//   rb_en/rb_addr -> rb_data/rb_valid/rb_busy   read port B (1-cycle)
//   wr_en/wr_addr/wr_data            write port (clears busy)
//   rsv_en/rsv_addr                  reservation (sets busy)
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ra_en,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_valid,
  output logic              ra_busy,
  input  logic              rb_en,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              rb_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              rsv_ok;

  // writes and reservations to the zero register are dropped here, so
  // neither storage nor the bypass paths ever see them
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(REG_ZERO)));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]  <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      // later assignment wins: reservation beats the write's clear
      if (rsv_ok)
        busy[rsv_addr] <= 1'b1;
    end
  end

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .en       (ra_en),
    .addr     (ra_addr),
    .mem_word (mem[ra_addr]),
    .busy_bit (busy[ra_addr]),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_ok),
    .rsv_addr (rsv_addr),
    .data     (ra_data),
    .valid    (ra_valid),
    .busy     (ra_busy)
  );

  regfile_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .en       (rb_en),
    .addr     (rb_addr),
    .mem_word (mem[rb_addr]),
    .busy_bit (busy[rb_addr]),
    .wr_en    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_ok),
    .rsv_addr (rsv_addr),
    .data     (rb_data),
    .valid    (rb_valid),
    .busy     (rb_busy)
  );

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised general-purpose register file for the 16-bit Harvard core; replaces the single-port combinational register array.
- Two independent registered read ports and one synchronous write port, with write-to-read bypass.
- Optional hardwired zero register and a per-register busy scoreboard for the decode stage's hazard detection.
- Sits between decode (read addresses, reservations) and writeback (write port).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations.
- INIT_IDX, 1, 1 = reset loads register i with value i (truncated to DATA_W); 0 = reset loads 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ra_en  in  1  read port A request.
- ra_addr  in  ADDR_W  read port A address.
- ra_data  out  DATA_W  read port A data, registered.
- ra_valid  out  1  ra_data/ra_busy valid this cycle.
- ra_busy  out  1  busy bit of the register read on port A.
- rb_en, rb_addr, rb_data, rb_valid, rb_busy: same as port A, for port B.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve a register (sets its busy bit).
- rsv_addr  in  ADDR_W  register to reserve.

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-high reset, reset. All state updates on the rising edge of clk.
- Reset (wins over every other input that cycle):
  - register i <= (INIT_IDX ? i : 0); register 0 <= 0 when ZERO_REG=1.
  - all busy bits <= 0.
  - ra_data, rb_data <= 0; ra_valid, rb_valid <= 0; ra_busy, rb_busy <= 0.
- Reset mid-operation discards any pending read result; the first valid read is 1 cycle after the first cycle with reset low and ra_en/rb_en high.
- Write: wr_en=1 at edge -> mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read latency is 1 cycle. ra_en=1 at edge N -> at N+1:
  - ra_valid=1.
  - ra_data = value of mem[ra_addr] after the edge-N write is applied (write-first bypass): if wr_en && wr_addr==ra_addr at edge N, ra_data = wr_data.
  - ra_busy = busy bit after edge-N updates.
- ra_en=0 -> ra_valid <= 0; ra_data and ra_busy hold their previous values.
- Port B is identical and independent. Both ports may read the same address in the same cycle.
- Zero register: with ZERO_REG=1, a read of address 0 returns data 0 and busy 0, with no bypass.
- Scoreboard: rsv_en=1 -> busy[rsv_addr] <= 1 (ignored for address 0 when ZERO_REG=1).
- Simultaneous rsv_en and wr_en to the same address: busy ends at 1 (the new reservation wins), data is written.
- Busy bypass on a read in the same cycle as rsv/wr to that address reflects the post-edge busy value under the rule above.
- Writes to different addresses never disturb each other. No address is out of range, because depth = 2**ADDR_W.
- No combinational path from any input to any output.

Decomposition:
- Shared package (e.g. cpu_pkg) holds:
  - DATA_W/ADDR_W defaults.
  - the reg-address typedef (ADDR_W bits) and the data-word typedef.
  - the constant REG_ZERO = 0.
- One natural sub-module, regfile_read_port: per-port output register, bypass mux, zero-register masking and valid flag. It is instantiated twice.
- The storage array and busy vector stay in the top module.

Test Plan:
- Reset with INIT_IDX=1, then read A=5, B=31 -> next cycle ra_data=5, rb_data=31, both valid=1, both busy=0.
- Write r7=0xBEEF, with read A=7 in the same cycle -> next cycle ra_data=0xBEEF (bypass). Read B=7 on the following cycle -> rb_data=0xBEEF.
- ZERO_REG=1: write r0=0x1234, rsv r0, then read A=0 -> ra_data=0, ra_busy=0.
- rsv r3, then read A=3 -> ra_busy=1. Write r3=0x00AA -> next read gives ra_busy=0, ra_data=0x00AA. Simultaneous rsv r3 and write r3=0x55 -> read gives data 0x55, busy=1.
- Assert reset while a read of r9 is in flight after writing r9=0xFFFF -> next cycle ra_valid=0, ra_data=0. A subsequent read of r9 returns 9.
- ra_en=0 for 3 cycles after a valid read of 0x0042 -> ra_valid=0, ra_data stays 0x0042.
